// File: rtl/escreg_arbitro.sv
// Register-file write-port arbiter between the WB stage and the mult/div unit.
// Optional macro ESCREG_FILTRO_R0_EN suppresses register-0 writes.
module escreg_arbitro #(
    parameter int ANCHO      = 32,
    parameter int DIRS       = 5,
    parameter int MAX_ESPERA = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_esc,
    input  logic [DIRS-1:0]  wb_dir,
    input  logic [ANCHO-1:0] wb_dato,
    input  logic             md_valido,
    input  logic [DIRS-1:0]  md_dir,
    input  logic [ANCHO-1:0] md_dato,
    output logic             md_listo,
    output logic             estancar,
    output logic             esc_reg,
    output logic [DIRS-1:0]  dir_esc,
    output logic [ANCHO-1:0] dato_esc
);

    typedef enum logic {LIBRE, FORZAR} estado_t;

    estado_t          estado, estado_sig;
    logic [3:0]       espera, espera_sig;
    logic             gana_md, gana_wb, conflicto, escribe;
    logic [DIRS-1:0]  dir_sel;
    logic [ANCHO-1:0] dato_sel;

    always_comb begin
        estado_sig = LIBRE;
        espera_sig = espera;
        gana_md    = 1'b0;
        gana_wb    = 1'b0;
        estancar   = 1'b0;
        md_listo   = 1'b0;

`ifdef ESCREG_FILTRO_R0_EN
        conflicto = md_valido & wb_esc & (md_dir == wb_dir) & (md_dir != '0);
`else
        conflicto = md_valido & wb_esc & (md_dir == wb_dir);
`endif

        case (estado)
            FORZAR: begin
                gana_md  = md_valido;
                estancar = wb_esc;
            end
            default: begin
                if (conflicto) begin
                    gana_md  = 1'b1;
                    estancar = 1'b1;
                end else if (wb_esc) begin
                    gana_wb = 1'b1;
                end else if (md_valido) begin
                    gana_md = 1'b1;
                end
            end
        endcase

        // An acceptance during reset would be lost, so it is not signalled.
        md_listo = gana_md & ~reset;

        if (!md_valido || md_listo)
            espera_sig = '0;
        else if (espera < 4'(MAX_ESPERA))
            espera_sig = espera + 4'd1;

        if (estado == LIBRE && espera_sig == 4'(MAX_ESPERA))
            estado_sig = FORZAR;

        dir_sel  = gana_md ? md_dir  : wb_dir;
        dato_sel = gana_md ? md_dato : wb_dato;
`ifdef ESCREG_FILTRO_R0_EN
        escribe = (gana_md | gana_wb) & (dir_sel != '0);
`else
        escribe = gana_md | gana_wb;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= LIBRE;
            espera   <= '0;
            esc_reg  <= 1'b0;
            dir_esc  <= '0;
            dato_esc <= '0;
        end else begin
            estado  <= estado_sig;
            espera  <= espera_sig;
            esc_reg <= escribe;
            if (escribe) begin
                dir_esc  <= dir_sel;
                dato_esc <= dato_sel;
            end
        end
    end

endmodule

// File: doc/escreg_arbitro.md
Name: escreg_arbitro

Overview:
- Arbitrates the single register-file write port (EscReg enable, address, data) between two requesters.
- Requester 1: pipeline WB stage, the normal priority requester.
- Requester 2: the multicycle mult/div unit (MD), which raises a valid/ready result request.
- Bounds MD starvation with a wait counter that forces an MD grant and stalls WB.
- Orders same-destination writes so the older MD result lands first.

Parameters:
- ANCHO, 32, data width of a register write.
- DIRS, 5, register address width.
- MAX_ESPERA, 4, consecutive denied MD cycles before a forced MD grant; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_esc  in  1  WB stage requests a register write.
- wb_dir  in  DIRS  WB destination register.
- wb_dato  in  ANCHO  WB write data.
- md_valido  in  1  MD result valid, held until accepted.
- md_dir  in  DIRS  MD destination register.
- md_dato  in  ANCHO  MD result data.
- md_listo  out  1  MD result accepted this cycle (combinational).
- estancar  out  1  WB write not accepted this cycle; pipeline must hold WB stage contents (combinational).
- esc_reg  out  1  registered write enable to register file.
- dir_esc  out  DIRS  registered write address.
- dato_esc  out  ANCHO  registered write data.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: esc_reg=0, dir_esc=0, dato_esc=0, state=LIBRE, espera=0.
  - md_listo and estancar then evaluate from inputs with state LIBRE.
  - Reset mid-operation discards any pending grant; no write is issued in the reset cycle or the cycle after.
- Latency: the winner sampled in cycle t appears on esc_reg/dir_esc/dato_esc in cycle t+1, exactly one write per grant.
  - With no grant, esc_reg=0 and dir_esc/dato_esc hold their previous values.
- Wait counter espera: width 4 bits.
  - Increments on every cycle with md_valido=1 and md_listo=0.
  - Clears on md_listo=1 or md_valido=0.
  - Saturates at MAX_ESPERA.
- FSM states:
  - LIBRE: normal arbitration.
  - FORZAR: one-cycle forced MD grant.
- LIBRE grant rules, in priority order:
  - (a) md_valido & wb_esc & md_dir==wb_dir: grant MD, md_listo=1, estancar=1 (older MD write lands first, WB re-presented next cycle).
  - (b) wb_esc=1: grant WB, estancar=0, md_listo=0.
  - (c) md_valido=1: grant MD, md_listo=1.
  - (d) otherwise no grant.
- LIBRE -> FORZAR: when espera will equal MAX_ESPERA after this cycle's update.
- FORZAR: md_valido is guaranteed high there (held until accepted).
  - Grant MD, md_listo=1.
  - estancar=wb_esc.
  - Next state LIBRE unconditionally; espera cleared.
- Bound: an MD request is accepted within MAX_ESPERA+1 cycles of first assertion.
- estancar=1 is only ever asserted in the same cycle as a WB request; estancar=0 whenever wb_esc=0.
- No grant ever goes to both requesters in one cycle.
- md_listo=0 whenever md_valido=0.

Optional Feature:
- Macro: ESCREG_FILTRO_R0_EN.
- Defined:
  - A granted write with destination 0 is still consumed (md_listo/no stall as per the rules above) but produces esc_reg=0 in t+1.
  - Rule (a) does not apply when both addresses are 0; WB wins per rule (b).
- Undefined: writes to register 0 are passed through like any other address.

Test Plan:
- WB-only path.
  - Stimulus: reset 2 cycles, then wb_esc=1, wb_dir=5, wb_dato=0x0000_00AA, md_valido=0.
  - Required: next cycle esc_reg=1, dir_esc=5, dato_esc=0xAA; estancar=0; after reset all outputs 0.
- Conflict, different destinations.
  - Stimulus: wb_esc=1 dir 3 and md_valido=1 dir 7, both held.
  - Required: WB granted on cycles 0..3, espera reaches 4.
  - Required: cycle 4 is FORZAR with md_listo=1, estancar=1, and the write dir 7 appears in cycle 5; WB dir 3 writes in cycle 6.
- Same destination.
  - Stimulus: wb_esc=1 dir 9 data 0x11 and md_valido=1 dir 9 data 0x22 in the same cycle.
  - Required: write 0x22 first, then 0x11; estancar=1 for exactly one cycle.
- MD alone.
  - Stimulus: md_valido=1 dir 12 with wb_esc=0.
  - Required: md_listo=1 same cycle; esc_reg=1, dir_esc=12 next cycle; espera stays 0.
- Reset mid-operation.
  - Stimulus: assert reset in the FORZAR cycle.
  - Required: md_listo is not honoured, esc_reg=0 in the following cycle, state=LIBRE, espera=0.
- Feature on (ESCREG_FILTRO_R0_EN).
  - Stimulus: wb_esc=1 dir 0.
  - Required: esc_reg stays 0; estancar=0.
- Feature off.
  - Stimulus: wb_esc=1 dir 0.
  - Required: esc_reg=1, dir_esc=0.
